// File: rtl/read_burst_collector.sv
// Read-path burst collector: queues issued read commands, assembles the DDR beats
// that return read_latency cycles later into burst words, and flags timing errors.
module read_burst_collector #(
  parameter int ADDR_W    = 29,
  parameter int DQ_W      = 8,
  parameter int CMD_DEPTH = 8
) (
  input  logic                         clock_t,
  input  logic                         reset,
  input  logic [4:0]                   read_latency,
  input  logic                         rd_cmd_valid,
  output logic                         rd_cmd_ready,
  input  logic [ADDR_W-1:0]            rd_cmd_addr,
  input  logic                         rd_cmd_bl8,
  input  logic                         dq_valid,
  input  logic [DQ_W-1:0]              dq_rise,
  input  logic [DQ_W-1:0]              dq_fall,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [8*DQ_W-1:0]            out_data,
  output logic                         out_bl8,
  output logic                         err_missing,
  output logic                         err_unexpected,
  output logic                         err_gap,
  output logic                         err_overflow,
  output logic [$clog2(CMD_DEPTH):0]   pending_count
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int BW = 2 * DQ_W;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(CMD_DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [7:0]          now_q;
  logic [1:0]          cnt_q, cnt_d;
  logic [8*DQ_W-1:0]   word_q, word_d;

  logic [ADDR_W-1:0]   cq_addr [CMD_DEPTH];
  logic                cq_bl8  [CMD_DEPTH];
  logic [7:0]          cq_due  [CMD_DEPTH];
  logic [PW-1:0]       cwr_q, crd_q;
  logic [PW:0]         ccnt_q;

  logic [ADDR_W-1:0]   ob_addr_q [2];
  logic [8*DQ_W-1:0]   ob_data_q [2];
  logic                ob_bl8_q  [2];
  logic                ob_wr_q, ob_rd_q;
  logic [1:0]          ocnt_q;

  logic err_missing_q, err_unexpected_q, err_gap_q, err_overflow_q;
  logic miss_d, unexp_d, gap_d, ovf_d;

  logic       cmd_empty, cmd_push, cmd_pop;
  logic [7:0] diff;
  logic       at_due, late;
  logic       ob_push, ob_pop, ob_accept;

  assign rd_cmd_ready  = (ccnt_q != FULL_CNT);
  assign cmd_push      = rd_cmd_valid && rd_cmd_ready;
  assign cmd_empty     = (ccnt_q == '0);
  assign pending_count = ccnt_q;

  // Modular distance to the head's due cycle; 1..127 means the slot has passed.
  assign diff   = now_q - cq_due[crd_q];
  assign at_due = !cmd_empty && (diff == 8'd0);
  assign late   = !cmd_empty && (diff != 8'd0) && !diff[7];

  assign out_valid      = (ocnt_q != 2'd0);
  assign out_addr       = ob_addr_q[ob_rd_q];
  assign out_data       = ob_data_q[ob_rd_q];
  assign out_bl8        = ob_bl8_q[ob_rd_q];
  assign ob_pop         = out_valid && out_ready;
  assign ob_accept      = ob_push && ((ocnt_q != 2'd2) || ob_pop);
  assign ovf_d          = ob_push && !ob_accept;

  assign err_missing    = err_missing_q;
  assign err_unexpected = err_unexpected_q;
  assign err_gap        = err_gap_q;
  assign err_overflow   = err_overflow_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    cmd_pop = 1'b0;
    ob_push = 1'b0;
    miss_d  = 1'b0;
    unexp_d = 1'b0;
    gap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (at_due) begin
          if (dq_valid) begin
            word_d         = '0;
            word_d[BW-1:0] = {dq_fall, dq_rise};
            cnt_d          = 2'd1;
            state_d        = BURST;
          end else begin
            miss_d  = 1'b1;
            cmd_pop = 1'b1;
          end
        end else begin
          if (late) begin
            miss_d  = 1'b1;
            cmd_pop = 1'b1;
          end
          unexp_d = dq_valid;
        end
      end
      BURST: begin
        if (dq_valid) begin
          word_d[int'(cnt_q)*BW +: BW] = {dq_fall, dq_rise};
          if (cnt_q == (cq_bl8[crd_q] ? 2'd3 : 2'd1)) begin
            cmd_pop = 1'b1;
            ob_push = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          gap_d   = 1'b1;
          cmd_pop = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clock_t) begin
    if (cmd_push) begin
      cq_addr[cwr_q] <= rd_cmd_addr;
      cq_bl8[cwr_q]  <= rd_cmd_bl8;
      cq_due[cwr_q]  <= now_q + {3'b000, read_latency};
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state_q          <= IDLE;
      now_q            <= '0;
      cnt_q            <= '0;
      word_q           <= '0;
      cwr_q            <= '0;
      crd_q            <= '0;
      ccnt_q           <= '0;
      ob_wr_q          <= 1'b0;
      ob_rd_q          <= 1'b0;
      ocnt_q           <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        ob_addr_q[i] <= '0;
        ob_data_q[i] <= '0;
        ob_bl8_q[i]  <= 1'b0;
      end
      err_missing_q    <= 1'b0;
      err_unexpected_q <= 1'b0;
      err_gap_q        <= 1'b0;
      err_overflow_q   <= 1'b0;
    end else begin
      now_q            <= now_q + 8'd1;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      word_q           <= word_d;
      err_missing_q    <= miss_d;
      err_unexpected_q <= unexp_d;
      err_gap_q        <= gap_d;
      err_overflow_q   <= ovf_d;

      if (cmd_push) cwr_q <= cwr_q + 1'b1;
      if (cmd_pop)  crd_q <= crd_q + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   ccnt_q <= ccnt_q + 1'b1;
        2'b01:   ccnt_q <= ccnt_q - 1'b1;
        default: ccnt_q <= ccnt_q;
      endcase

      if (ob_accept) begin
        ob_addr_q[ob_wr_q] <= cq_addr[crd_q];
        ob_data_q[ob_wr_q] <= word_d;
        ob_bl8_q[ob_wr_q]  <= cq_bl8[crd_q];
        ob_wr_q            <= ~ob_wr_q;
      end
      if (ob_pop) ob_rd_q <= ~ob_rd_q;
      case ({ob_accept, ob_pop})
        2'b10:   ocnt_q <= ocnt_q + 2'd1;
        2'b01:   ocnt_q <= ocnt_q - 2'd1;
        default: ocnt_q <= ocnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_read_burst_collector.sv
// Directed-vector bench for read_burst_collector with a queue scoreboard checked
// by an independent output monitor.
module tb_read_burst_collector;
  localparam int AW = 29;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int NC = 300;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    read_latency;
  logic          rd_cmd_valid, rd_cmd_ready, rd_cmd_bl8;
  logic [AW-1:0] rd_cmd_addr;
  logic          dq_valid;
  logic [DW-1:0] dq_rise, dq_fall;
  logic          out_valid, out_ready, out_bl8;
  logic [AW-1:0] out_addr;
  logic [63:0]   out_data;
  logic          err_missing, err_unexpected, err_gap, err_overflow;
  logic [3:0]    pending_count;

  always #5 clk = ~clk;

  read_burst_collector #(.ADDR_W(AW), .DQ_W(DW), .CMD_DEPTH(DEPTH)) dut (
    .clock_t(clk), .reset(reset), .read_latency(read_latency),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_bl8(rd_cmd_bl8),
    .dq_valid(dq_valid), .dq_rise(dq_rise), .dq_fall(dq_fall),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_bl8(out_bl8),
    .err_missing(err_missing), .err_unexpected(err_unexpected),
    .err_gap(err_gap), .err_overflow(err_overflow),
    .pending_count(pending_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic          bl8;
  } word_t;

  word_t expq[$];
  word_t mon_exp;
  int n_checks = 0, n_fail = 0;
  int words_seen, n_miss, n_unexp, n_gap, n_ovf, valid_cyc, cyc;

  bit            cv [NC];
  logic [AW-1:0] ca [NC];
  bit            cb [NC];
  bit            dv [NC];
  logic [7:0]    dr [NC];
  logic [7:0]    df [NC];
  bit            rdy[NC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and tallies error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_missing)    n_miss++;
      if (err_unexpected) n_unexp++;
      if (err_gap)        n_gap++;
      if (err_overflow)   n_ovf++;
      if (out_valid && valid_cyc < 0) valid_cyc = cyc;
      if (out_valid && out_ready) begin
        words_seen++;
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL word_unexpected: got addr 0x%0h data 0x%0h, required no word", out_addr, out_data);
        end else begin
          mon_exp = expq.pop_front();
          check("word_addr", 64'(out_addr), 64'(mon_exp.addr));
          check("word_data", out_data, mon_exp.data);
          check("word_bl8", 64'(out_bl8), 64'(mon_exp.bl8));
        end
      end
    end
  end

  task automatic clear_sched();
    for (int i = 0; i < NC; i++) begin
      cv[i] = 1'b0; ca[i] = '0; cb[i] = 1'b0;
      dv[i] = 1'b0; dr[i] = '0; df[i] = '0; rdy[i] = 1'b1;
    end
  endtask

  task automatic add_cmd(input int c, input logic [AW-1:0] a, input bit b);
    cv[c] = 1'b1; ca[c] = a; cb[c] = b;
  endtask

  task automatic add_beats(input int c, input logic [63:0] d, input int nclk);
    for (int k = 0; k < nclk; k++) begin
      dv[c+k] = 1'b1;
      dr[c+k] = d[16*k +: 8];
      df[c+k] = d[16*k+8 +: 8];
    end
  endtask

  task automatic expect_word(input logic [AW-1:0] a, input logic [63:0] d, input bit b);
    word_t w;
    w.addr = a; w.data = d; w.bl8 = b;
    expq.push_back(w);
  endtask

  task automatic run(input int from, input int to);
    for (int c = from; c < to; c++) begin
      cyc          = c;
      rd_cmd_valid = cv[c];
      rd_cmd_addr  = ca[c];
      rd_cmd_bl8   = cb[c];
      dq_valid     = dv[c];
      dq_rise      = dr[c];
      dq_fall      = df[c];
      out_ready    = rdy[c];
      @(posedge clk);
      #1;
    end
    cyc          = to;
    rd_cmd_valid = 1'b0;
    dq_valid     = 1'b0;
  endtask

  task automatic do_reset(input logic [4:0] rl);
    reset        = 1'b1;
    read_latency = rl;
    out_ready    = 1'b1;
    rd_cmd_valid = 1'b0;
    rd_cmd_addr  = '0;
    rd_cmd_bl8   = 1'b0;
    dq_valid     = 1'b0;
    dq_rise      = '0;
    dq_fall      = '0;
    expq.delete();
    words_seen = 0; n_miss = 0; n_unexp = 0; n_gap = 0; n_ovf = 0;
    valid_cyc = -1; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_sched();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_addr"}, 64'(out_addr), 64'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_out_bl8"}, 64'(out_bl8), 64'd0);
    check({tag, "_errs"}, 64'({err_missing, err_unexpected, err_gap, err_overflow}), 64'd0);
    check({tag, "_pending"}, 64'(pending_count), 64'd0);
    check({tag, "_cmd_ready"}, 64'(rd_cmd_ready), 64'd1);
  endtask

  task automatic check_errs(input string tag, input int m, input int u, input int g, input int o);
    check({tag, "_err_missing"}, 64'(n_miss), 64'(m));
    check({tag, "_err_unexpected"}, 64'(n_unexp), 64'(u));
    check({tag, "_err_gap"}, 64'(n_gap), 64'(g));
    check({tag, "_err_overflow"}, 64'(n_ovf), 64'(o));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic BL8 read with first-beat latency and output timing
    do_reset(5'd11);
    check_reset_vals("reset");
    add_cmd(5, 29'h0000123, 1'b1);
    add_beats(16, 64'h0807060504030201, 4);
    expect_word(29'h0000123, 64'h0807060504030201, 1'b1);
    run(0, 30);
    check("t1_valid_cycle", 64'(valid_cyc), 64'd20);
    check("t1_words", 64'(words_seen), 64'd1);
    check_errs("t1", 0, 0, 0, 0);

    // BC4 followed by BL8 due the cycle after its last beat
    do_reset(5'd11);
    add_cmd(0, 29'h00000AB, 1'b0);
    add_beats(11, 64'h00000000DDCCBBAA, 2);
    expect_word(29'h00000AB, 64'h00000000DDCCBBAA, 1'b0);
    add_cmd(2, 29'h00000CD, 1'b1);
    add_beats(13, 64'h1122334455667788, 4);
    expect_word(29'h00000CD, 64'h1122334455667788, 1'b1);
    run(0, 30);
    check("t2_words", 64'(words_seen), 64'd2);
    check_errs("t2", 0, 0, 0, 0);

    // Due cycle wraps the 8-bit counter, then a stray beat
    do_reset(5'd20);
    add_cmd(250, 29'h1ABCDEF0, 1'b1);
    add_beats(270, 64'hF0E1D2C3B4A59687, 4);
    expect_word(29'h1ABCDEF0, 64'hF0E1D2C3B4A59687, 1'b1);
    dv[285] = 1'b1; dr[285] = 8'h5A; df[285] = 8'hA5;
    run(0, 295);
    check("t3_words", 64'(words_seen), 64'd1);
    check_errs("t3", 0, 1, 0, 0);

    // Missing burst, recovery, then a burst that stops after two clocks
    do_reset(5'd11);
    add_cmd(0, 29'h0000AAA, 1'b1);
    add_cmd(3, 29'h0000BBB, 1'b1);
    add_beats(14, 64'h0102030405060708, 4);
    expect_word(29'h0000BBB, 64'h0102030405060708, 1'b1);
    add_cmd(30, 29'h0000CCC, 1'b1);
    add_beats(41, 64'hDEADBEEFCAFEF00D, 2);
    run(0, 60);
    check("t4_words", 64'(words_seen), 64'd1);
    check_errs("t4", 1, 0, 1, 0);

    // Consumer stalled across three bursts: two held, third overflows
    do_reset(5'd11);
    add_cmd(0, 29'h0000111, 1'b1);
    add_cmd(4, 29'h0000222, 1'b1);
    add_cmd(8, 29'h0000333, 1'b1);
    add_beats(11, 64'hA1A2A3A4A5A6A7A8, 4);
    add_beats(15, 64'hB1B2B3B4B5B6B7B8, 4);
    add_beats(19, 64'hC1C2C3C4C5C6C7C8, 4);
    expect_word(29'h0000111, 64'hA1A2A3A4A5A6A7A8, 1'b1);
    expect_word(29'h0000222, 64'hB1B2B3B4B5B6B7B8, 1'b1);
    for (int i = 0; i < 30; i++) rdy[i] = 1'b0;
    run(0, 25);
    check("t5_hold_valid", 64'(out_valid), 64'd1);
    check("t5_hold_addr", 64'(out_addr), 64'h111);
    check("t5_hold_data", out_data, 64'hA1A2A3A4A5A6A7A8);
    check("t5_ovf_before_drain", 64'(n_ovf), 64'd1);
    run(25, 40);
    check("t5_words", 64'(words_seen), 64'd2);
    check("t5_drained_valid", 64'(out_valid), 64'd0);
    check_errs("t5", 0, 0, 0, 1);

    // Command FIFO fills, then reset lands mid-burst
    do_reset(5'd31);
    for (int i = 0; i < 9; i++) add_cmd(i, AW'(32'h100 + i), 1'b1);
    add_beats(31, 64'h5555666677778888, 2);
    run(0, 9);
    check("t6_cmd_ready_full", 64'(rd_cmd_ready), 64'd0);
    check("t6_pending_full", 64'(pending_count), 64'd8);
    run(9, 33);
    check("t6_pending_mid_burst", 64'(pending_count), 64'd8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("t6_reset");
    reset = 1'b0;
    clear_sched();
    run(0, 10);
    check("t6_words", 64'(words_seen), 64'd0);
    check("t6_pending_after", 64'(pending_count), 64'd0);
    check_errs("t6", 0, 0, 0, 0);

    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
